uart_rx_mmio: RTL
=================

Name: uart_rx_mmio

Overview:
- Memory-mapped UART receiver: 8N1 serial in, depth-parameterised receive FIFO, status/control registers, level interrupt for the core's `interupt` input.
- Counterpart of the existing UART transmitter (`uart_output` / `uart_busy`) on the data-memory bus.
- Core polls STATUS or takes the interrupt, then reads DATA, which pops the FIFO.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 8, receive FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart_input  in  1  asynchronous serial line, idle high
- sel  in  1  block selected by address decode
- rd  in  1  read strobe (qualified by sel)
- wr  in  1  write strobe (qualified by sel)
- addr  in  2  word offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved
- wdata  in  32  write data
- rdata  out  32  read data, registered, valid the cycle after rd
- irq  out  1  interrupt request, registered

Behaviour:
- Reset values:
  - rdata = 0, irq = 0
  - FIFO empty, STATUS sticky bits = 0, CTRL = 0
  - FSM = IDLE, synchroniser flops = 1
- Input: 2-flop synchroniser on uart_input. All sampling uses the synchronised bit (2-cycle latency).
- FSM:
  - IDLE: on synced bit = 0, load counter = CLKS_PER_BIT/2 - 1 and go to START.
  - START: count down. At 0, if bit still 0, load CLKS_PER_BIT - 1, clear bit index, go to DATA; if bit = 1 (glitch), return to IDLE and push nothing.
  - DATA: at counter 0, shift in the sampled bit LSB-first and reload CLKS_PER_BIT - 1. After bit 7, go to STOP.
  - STOP: at counter 0, sample the line and go to IDLE.
    - Sample 1: push byte.
    - Sample 0: set FERR, discard byte.
- Push when FIFO full:
  - Byte dropped, OVR set.
  - Exception: a DATA pop in the same cycle frees a slot, so the push is accepted.
- Reg DATA read:
  - Not empty: rdata = {24'b0, head byte}, head pops in the same cycle.
  - Empty: rdata = 0, no pointer change.
  - Writes to DATA are ignored.
- Reg STATUS read: bit0 NE (not empty), bit1 FULL, bit2 OVR, bit3 FERR, bit4 PERR, bits[11:8] occupancy count; other bits 0.
- Reg STATUS write: write-1-to-clear on bits 2–4. If a clear and a new set event land in the same cycle, set wins.
- Reg CTRL: bit0 IE, read/write; other bits read 0.
- Reserved offset 3: reads 0, writes ignored.
- rd and wr in the same cycle: both act; rdata shows the pre-write value.
- Strobes with sel = 0 are ignored.
- irq = IE & (NE | OVR | FERR), registered, one cycle after the condition.
- Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit. Full = pointers equal except for the wrap bit.
- Reset mid-frame: FSM returns to IDLE, partial byte discarded, FIFO cleared.
- Reception continues independently of bus activity. Back-to-back frames are accepted with a 1-bit stop only.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: even parity bit between bit 7 and stop, sampled like a data bit in a PARITY state.
  - On mismatch, set PERR and discard the byte (FERR is still checked; both may set).
  - irq also includes PERR.
- Not defined: 8N1 only, STATUS bit4 reads 0, no PARITY state.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - register offset constants
  - STATUS bit-index constants
  - default CLKS_PER_BIT
- Sub-module uart_rx_fifo:
  - synchronous FIFO with push, pop, din, dout, full, empty, count
  - same clk/reset

Test Plan (all with CLKS_PER_BIT = 4):
1. Send 0xA5 8N1 -> FIFO holds 1 entry, STATUS reads 0x101. DATA read returns 0x000000A5, then STATUS reads 0x000.
2. Set CTRL = 1, send 0x3C -> irq rises within 2 cycles of the stop sample. DATA read returns 0x3C, irq falls the next cycle.
3. Send 9 bytes 0x00..0x08 with no reads (DEPTH 8) -> STATUS shows FULL, OVR, count 8. Reads return 0x00..0x07. Writing STATUS = 0x4 clears OVR.
4. Send 0x55 with stop bit forced 0 -> FERR set, FIFO empty, DATA reads 0.
5. 1-cycle low glitch on idle line -> no push, FSM back to IDLE, STATUS = 0. Reset asserted mid-byte -> all state 0, next clean 0x81 is received correctly.
6. With UART_RX_PARITY_EN: send 0x07 with parity 1 -> accepted. Send 0x07 with parity 0 -> PERR set (STATUS bit4), byte discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
package uart_pkg;

    // Receiver frame states; PARITY is only visited when UART_RX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Register word offsets on the data-memory bus
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int ST_NE      = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVR     = 2;
    localparam int ST_FERR    = 3;
    localparam int ST_PERR    = 4;
    localparam int ST_CNT_LSB = 8;

    // 50 MHz / 115200 baud
    localparam int DEF_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received characters. Pointers carry an extra
// wrap bit so full and empty can be told apart without a separate counter.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign dout    = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);

    // Pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 8N1 deserialiser, receive FIFO, STATUS/CTRL
// registers and a level interrupt. Define UART_RX_PARITY_EN for 8E1 framing
// with a PERR sticky bit.
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_input,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int          CW    = $clog2(CLKS_PER_BIT);
    localparam int          FAW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync1_q, sync2_q, rx_bit;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          frame_end, push_req, ferr_set, perr_set;
    logic          ovr_q, ferr_q, perr_q, ie_q, irq_q;
    logic [31:0]   rdata_q, status_w;
    logic          bus_rd, bus_wr, pop, ovr_set, irq_d;
    logic [31:0]   clr;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [FAW:0]  fifo_count;
    logic          unused_wdata;

    assign rx_bit = sync2_q;

    // Two-flop synchroniser on the asynchronous serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_input;
            sync2_q <= sync1_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q;
`endif

    // Frame FSM: centre-samples each bit off a down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (!rx_bit) begin
                    cnt_q   <= HALF_BIT;
                    state_q <= START;
                end
                START: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else if (!rx_bit) begin
                    cnt_q   <= FULL_BIT;
                    idx_q   <= '0;
                    state_q <= DATA;
                end else begin
                    state_q <= IDLE;
                end
                DATA: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else begin
                    shift_q <= {rx_bit, shift_q[7:1]};
                    cnt_q   <= FULL_BIT;
                    idx_q   <= idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_q <= PARITY;
`else
                    if (idx_q == 3'd7) state_q <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else begin
                    par_bad_q <= (^shift_q) ^ rx_bit;
                    cnt_q     <= FULL_BIT;
                    state_q   <= STOP;
                end
`endif
                STOP: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                else state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stop-bit sample cycle decides push / framing error
    assign frame_end = (state_q == STOP) && (cnt_q == '0);
    assign ferr_set  = frame_end && !rx_bit;
`ifdef UART_RX_PARITY_EN
    assign push_req  = frame_end && rx_bit && !par_bad_q;
    assign perr_set  = frame_end && par_bad_q;
`else
    assign push_req  = frame_end && rx_bit;
    assign perr_set  = 1'b0;
`endif

    assign bus_rd  = sel && rd;
    assign bus_wr  = sel && wr;
    assign pop     = bus_rd && (addr == REG_DATA) && !fifo_empty;
    assign ovr_set = push_req && fifo_full && !pop;
    assign clr     = (bus_wr && addr == REG_STATUS) ? wdata : 32'd0;
    assign unused_wdata = ^{wdata[31:5], wdata[1]};

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS word assembled from live FIFO state and sticky flags
    always_comb begin
        status_w                      = '0;
        status_w[ST_NE]               = !fifo_empty;
        status_w[ST_FULL]             = fifo_full;
        status_w[ST_OVR]              = ovr_q;
        status_w[ST_FERR]             = ferr_q;
        status_w[ST_PERR]             = perr_q;
        status_w[ST_CNT_LSB +: 4]     = 4'(fifo_count);
    end

`ifdef UART_RX_PARITY_EN
    assign irq_d = ie_q && (!fifo_empty || ovr_q || ferr_q || perr_q);
`else
    assign irq_d = ie_q && (!fifo_empty || ovr_q || ferr_q);
`endif

    // Sticky flags (set beats clear), CTRL, read data and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ie_q    <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ovr_q  <= (ovr_q  && !clr[ST_OVR])  || ovr_set;
            ferr_q <= (ferr_q && !clr[ST_FERR]) || ferr_set;
            perr_q <= (perr_q && !clr[ST_PERR]) || perr_set;
            if (bus_wr && addr == REG_CTRL) ie_q <= wdata[0];
            if (bus_rd) begin
                case (addr)
                    REG_DATA:   rdata_q <= fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                    REG_STATUS: rdata_q <= status_w;
                    REG_CTRL:   rdata_q <= {31'd0, ie_q};
                    default:    rdata_q <= '0;
                endcase
            end
            irq_q <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

endmodule
